// File: rtl/spi_arb_if.sv
// Requester and spi_phy byte-interface bundle for spi_arb.
// The slave modport is the arbiter's view; master is the environment's view.
interface spi_arb_if #(
    parameter int unsigned WIDTH = 8
);
    logic             i_req0, i_req1;
    logic             o_gnt0, o_gnt1;
    logic             i_wr0, i_wr1;
    logic [WIDTH-1:0] i_wdata0, i_wdata1;
    logic             o_bsy0, o_bsy1;
    logic             o_rdy0, o_rdy1;
    logic [WIDTH-1:0] o_rdata0, o_rdata1;
    logic             i_rd0, i_rd1;
    logic             o_wr;
    logic [WIDTH-1:0] o_wdata;
    logic             i_bsy;
    logic             i_rdy;
    logic [WIDTH-1:0] i_rdata;
    logic             o_rd;

    modport slave (
        input  i_req0, i_req1, i_wr0, i_wr1, i_wdata0, i_wdata1, i_rd0, i_rd1,
        input  i_bsy, i_rdy, i_rdata,
        output o_gnt0, o_gnt1, o_bsy0, o_bsy1, o_rdy0, o_rdy1, o_rdata0, o_rdata1,
        output o_wr, o_wdata, o_rd
    );

    modport master (
        output i_req0, i_req1, i_wr0, i_wr1, i_wdata0, i_wdata1, i_rd0, i_rd1,
        output i_bsy, i_rdy, i_rdata,
        input  o_gnt0, o_gnt1, o_bsy0, o_bsy1, o_rdy0, o_rdy1, o_rdata0, o_rdata1,
        input  o_wr, o_wdata, o_rd
    );
endinterface

// File: rtl/spi_arb.sv
// Two-requester arbiter for a shared spi_phy byte interface: alternating
// priority, drains the phy after release and enforces an idle gap between grants.
module spi_arb #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned GAP   = 4
) (
    input  logic     i_clk,
    input  logic     i_rst,
    spi_arb_if.slave bus
);
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GNT0,
        S_GNT1,
        S_DRAIN,
        S_GAPWAIT
    } state_e;

    state_e             state_q, state_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               gnt0_q, gnt0_d;
    logic               gnt1_q, gnt1_d;
    logic               drain_rd_q, drain_rd_d;

    // Next-state: arbitration, release, drain and gap countdown
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_req0 && bus.i_req1) begin
                    state_d = last_q ? S_GNT0 : S_GNT1;
                end else if (bus.i_req0) begin
                    state_d = S_GNT0;
                end else if (bus.i_req1) begin
                    state_d = S_GNT1;
                end
            end
            S_GNT0: begin
                if (!bus.i_req0) begin
                    state_d = S_DRAIN;
                    last_d  = 1'b0;
                end
            end
            S_GNT1: begin
                if (!bus.i_req1) begin
                    state_d = S_DRAIN;
                    last_d  = 1'b1;
                end
            end
            S_DRAIN: begin
                if (!bus.i_bsy && !bus.i_rdy) begin
                    state_d = S_GAPWAIT;
                    cnt_d   = GAP_LOAD;
                end
            end
            S_GAPWAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        gnt0_d     = (state_d == S_GNT0);
        gnt1_d     = (state_d == S_GNT1);
        // Remembers a discard already issued for the byte currently on i_rdy
        drain_rd_d = (state_q == S_DRAIN) && bus.i_rdy;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            last_q     <= 1'b1;
            cnt_q      <= '0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            drain_rd_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            drain_rd_q <= drain_rd_d;
        end
    end

    logic             wr_c, rd_c;
    logic [WIDTH-1:0] wdata_c;
    logic             bsy0_c, bsy1_c, rdy0_c, rdy1_c;

    // Phy passthrough to the owner; everyone else sees a busy, empty phy
    always_comb begin
        wr_c    = 1'b0;
        wdata_c = '0;
        rd_c    = (state_q == S_DRAIN) && bus.i_rdy && !drain_rd_q;
        bsy0_c  = 1'b1;
        bsy1_c  = 1'b1;
        rdy0_c  = 1'b0;
        rdy1_c  = 1'b0;
        case (state_q)
            S_GNT0: begin
                wr_c    = bus.i_wr0;
                wdata_c = bus.i_wdata0;
                rd_c    = bus.i_rd0;
                bsy0_c  = bus.i_bsy;
                rdy0_c  = bus.i_rdy;
            end
            S_GNT1: begin
                wr_c    = bus.i_wr1;
                wdata_c = bus.i_wdata1;
                rd_c    = bus.i_rd1;
                bsy1_c  = bus.i_bsy;
                rdy1_c  = bus.i_rdy;
            end
            default: ;
        endcase
    end

    assign bus.o_gnt0   = gnt0_q;
    assign bus.o_gnt1   = gnt1_q;
    assign bus.o_wr     = wr_c;
    assign bus.o_wdata  = wdata_c;
    assign bus.o_rd     = rd_c;
    assign bus.o_bsy0   = bsy0_c;
    assign bus.o_bsy1   = bsy1_c;
    assign bus.o_rdy0   = rdy0_c;
    assign bus.o_rdy1   = rdy1_c;
    assign bus.o_rdata0 = bus.i_rdata;
    assign bus.o_rdata1 = bus.i_rdata;
endmodule

// File: tb/tb_spi_arb.sv
// Self-checking bench for spi_arb: directed scenarios then randomized traffic,
// all compared against an ownership/blackout model of the arbiter.
module tb_spi_arb;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned GAP   = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_arb_if #(.WIDTH(WIDTH)) bus ();

    spi_arb #(.WIDTH(WIDTH), .GAP(GAP)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    // Model: who owns the phy, whether the phy is being flushed after a
    // release, how many edges remain before a new grant may be decided.
    int owner;      // -1 none, else requester index
    int last;       // requester that held the phy most recently
    bit draining;
    bit discarded;  // current unclaimed byte already thrown away
    int gap_left;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        owner = -1; last = 1; draining = 0; discarded = 0; gap_left = 0;
    endtask

    task automatic model_edge();
        bit r0, r1;
        r0 = bus.i_req0;
        r1 = bus.i_req1;
        if ((owner == 0 && !r0) || (owner == 1 && !r1)) begin
            last = owner; owner = -1; draining = 1; discarded = 0;
        end else if (owner >= 0) begin
            // owner keeps the phy
        end else if (draining) begin
            if (!bus.i_bsy && !bus.i_rdy) begin
                draining = 0; gap_left = GAP;
            end else begin
                discarded = bus.i_rdy;
            end
        end else if (gap_left > 0) begin
            gap_left--;
        end else if (r0 && r1) begin
            owner = (last == 0) ? 1 : 0;
        end else if (r0) begin
            owner = 0;
        end else if (r1) begin
            owner = 1;
        end
    endtask

    task automatic check_outputs();
        logic exp_wr, exp_rd;
        exp_wr = (owner == 0) ? bus.i_wr0 : (owner == 1) ? bus.i_wr1 : 1'b0;
        exp_rd = (owner == 0) ? bus.i_rd0 : (owner == 1) ? bus.i_rd1 :
                 (draining && bus.i_rdy && !discarded);
        chk("gnt0", 32'(bus.o_gnt0), 32'(owner == 0));
        chk("gnt1", 32'(bus.o_gnt1), 32'(owner == 1));
        chk("wr", 32'(bus.o_wr), 32'(exp_wr));
        chk("rd", 32'(bus.o_rd), 32'(exp_rd));
        chk("bsy0", 32'(bus.o_bsy0), 32'((owner == 0) ? bus.i_bsy : 1'b1));
        chk("bsy1", 32'(bus.o_bsy1), 32'((owner == 1) ? bus.i_bsy : 1'b1));
        chk("rdy0", 32'(bus.o_rdy0), 32'((owner == 0) ? bus.i_rdy : 1'b0));
        chk("rdy1", 32'(bus.o_rdy1), 32'((owner == 1) ? bus.i_rdy : 1'b0));
        chk("rdata0", 32'(bus.o_rdata0), 32'(bus.i_rdata));
        chk("rdata1", 32'(bus.o_rdata1), 32'(bus.i_rdata));
        if (owner == 0) chk("wdata0", 32'(bus.o_wdata), 32'(bus.i_wdata0));
        if (owner == 1) chk("wdata1", 32'(bus.o_wdata), 32'(bus.i_wdata1));
    endtask

    // Inputs are set just after a rising edge; outputs checked at the falling edge.
    task automatic tick();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        #1;
    endtask

    task automatic wait_gnt(input int k, input string tag);
        int n;
        n = 0;
        while (n < 32 && !((k == 0) ? bus.o_gnt0 : bus.o_gnt1)) begin
            tick();
            n++;
        end
        chk(tag, 32'((k == 0) ? bus.o_gnt0 : bus.o_gnt1), 32'd1);
    endtask

    initial begin
        int n;
        model_reset();
        rst = 1'b1;
        bus.i_req0 = 0; bus.i_req1 = 0; bus.i_wr0 = 0; bus.i_wr1 = 0;
        bus.i_rd0 = 0; bus.i_rd1 = 0; bus.i_wdata0 = '0; bus.i_wdata1 = '0;
        bus.i_bsy = 0; bus.i_rdy = 0; bus.i_rdata = '0;

        // Reset values, then first arbitration right after release
        #1;
        chk("rst_gnt0", 32'(bus.o_gnt0), 32'd0);
        chk("rst_bsy1", 32'(bus.o_bsy1), 32'd1);
        tick(); tick();
        rst = 1'b0;

        // Single grant and same-cycle write passthrough
        bus.i_req0 = 1;
        tick();
        chk("single_gnt0", 32'(bus.o_gnt0), 32'd1);
        bus.i_wr0 = 1; bus.i_wdata0 = 8'hA5;
        #1;
        chk("wr_pass", 32'(bus.o_wr), 32'd1);
        chk("wdata_pass", 32'(bus.o_wdata), 32'hA5);
        tick();

        // Lockout of the non-granted requester
        bus.i_wr0 = 0; bus.i_req1 = 1; bus.i_wr1 = 1; bus.i_wdata1 = 8'h5A;
        bus.i_bsy = 1; bus.i_rdy = 1;
        #1;
        chk("lock_wr", 32'(bus.o_wr), 32'd0);
        chk("lock_bsy1", 32'(bus.o_bsy1), 32'd1);
        chk("lock_rdy1", 32'(bus.o_rdy1), 32'd0);
        tick();
        bus.i_wr1 = 0; bus.i_bsy = 0; bus.i_rdy = 0;
        tick();

        // Release with the other requester pending: grant gap is GAP+2
        bus.i_req0 = 0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.o_gnt1 && n < 40);
        chk("grant_gap", 32'(n - 1), 32'(GAP + 2));

        // Release with an unread byte: exactly one discard pulse
        bus.i_req1 = 0; bus.i_rdy = 1; bus.i_rdata = 8'h3C;
        tick();
        chk("drain_rd", 32'(bus.o_rd), 32'd1);
        chk("drain_rdy1", 32'(bus.o_rdy1), 32'd0);
        tick();
        chk("drain_rd_once", 32'(bus.o_rd), 32'd0);
        bus.i_rdy = 0;
        for (int i = 0; i < GAP + 3; i++) tick();

        // Busy hold: no grant and no write while the phy stays busy
        bus.i_req0 = 1;
        wait_gnt(0, "wait_gnt0");
        bus.i_bsy = 1; bus.i_req0 = 0; bus.i_wr0 = 1; bus.i_req1 = 1;
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("busy_nogrant", 32'({bus.o_gnt0, bus.o_gnt1}), 32'd0);
            chk("busy_nowr", 32'(bus.o_wr), 32'd0);
            tick();
        end
        bus.i_bsy = 0; bus.i_wr0 = 0; bus.i_req0 = 1;
        wait_gnt(1, "alt_gnt1");

        // Reset mid-grant clears the grant at once; requester 0 wins afterwards
        #2 rst = 1'b1;
        #1;
        chk("async_rst_gnt1", 32'(bus.o_gnt1), 32'd0);
        model_reset();
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_gnt0", 32'(bus.o_gnt0), 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) bus.i_req0 = ~bus.i_req0;
            if ($urandom_range(0, 7) == 0) bus.i_req1 = ~bus.i_req1;
            bus.i_wr0    = 1'($urandom);
            bus.i_wr1    = 1'($urandom);
            bus.i_rd0    = 1'($urandom);
            bus.i_rd1    = 1'($urandom);
            bus.i_wdata0 = WIDTH'($urandom);
            bus.i_wdata1 = WIDTH'($urandom);
            bus.i_rdata  = WIDTH'($urandom);
            bus.i_bsy    = ($urandom_range(0, 2) == 0);
            bus.i_rdy    = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/spi_arb.md
SPI_ARB -- requirements
Module: spi_arb

Parameters
REQ-001 SHALL have parameter WIDTH, default 8: byte width of phy and requester data paths.
REQ-002 SHALL have parameter GAP, default 4: minimum idle cycles between successive grants, range 1..15.

Interface
REQ-003 SHALL have i_clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have i_rst  input  1  reset; asynchronous and active-high.
REQ-005 SHALL have i_req0, i_req1  input  1 each  requester k asks for or holds the phy.
REQ-006 SHALL have o_gnt0, o_gnt1  output  1 each  requester k owns the phy.
REQ-007 SHALL have i_wr0/i_wr1  input  1 and i_wdata0/i_wdata1  input  WIDTH: requester k write strobe and write data.
REQ-008 SHALL have o_bsy0/o_bsy1  output  1: phy busy as seen by requester k.
REQ-009 SHALL have o_rdy0/o_rdy1  output  1 and o_rdata0/o_rdata1  output  WIDTH: read data valid and read data for requester k.
REQ-010 SHALL have i_rd0/i_rd1  input  1: requester k read acknowledge.
REQ-011 SHALL have o_wr  output  1, o_wdata  output  WIDTH, i_bsy  input  1: write side of the spi_phy byte interface.
REQ-012 SHALL have i_rdy  input  1, i_rdata  input  WIDTH, o_rd  output  1: read side of the spi_phy byte interface.

Function
REQ-013 SHALL implement states IDLE, GNT0, GNT1, DRAIN, GAPWAIT.
REQ-014 IDLE SHALL move as follows on a clock edge:
- only i_req0 high -> GNT0.
- only i_req1 high -> GNT1.
- both high -> the requester not granted last; after reset, requester 0 wins.
REQ-015 o_gnt0 SHALL be high exactly in GNT0, and o_gnt1 exactly in GNT1 (registered, asserted the cycle after request seen in IDLE).
REQ-016 Passthrough SHALL be combinational while in GNTk and hold in all other states:
- o_wr = i_wrk; o_wdata = i_wdatak.
- o_rd = i_rdk.
- o_bsyk = i_bsy; o_rdyk = i_rdy.
REQ-017 o_rdatak SHALL equal i_rdata at all times; only o_rdyk is gated.
REQ-018 The non-granted requester SHALL see o_bsy=1 and o_rdy=0, and its i_wr/i_rd SHALL be ignored.
REQ-019 GNTk with i_reqk low SHALL go to DRAIN and record k as last granted.
REQ-020 DRAIN SHALL hold while i_bsy=1.
REQ-021 In DRAIN with i_rdy=1 (unclaimed byte), the block SHALL pulse o_rd for one cycle to discard it.
REQ-022 DRAIN SHALL exit to GAPWAIT in the first cycle with i_bsy=0 and i_rdy=0, loading a 4-bit counter with GAP-1.
REQ-023 GAPWAIT SHALL decrement the counter each cycle and go to IDLE when it reads 0.
REQ-024 Grant-to-grant spacing SHALL therefore be at least GAP+2 cycles.
REQ-025 Requests arriving in DRAIN or GAPWAIT SHALL be held pending, not lost, and arbitrated in IDLE per REQ-014.
REQ-026 A requester that drops and re-raises i_req in the same GNT cycle SHALL NOT retain the grant; the drop is sampled and REQ-019 applies.
REQ-027 o_wr SHALL never be high in DRAIN, GAPWAIT or IDLE.
REQ-028 o_rd SHALL be high outside GNTk only per REQ-021.

Reset
REQ-029 On i_rst high, the block SHALL immediately enter IDLE, including mid-transaction.
REQ-030 On i_rst high, state SHALL take these values: o_gnt0=o_gnt1=0, o_wr=0, o_rd=0, o_bsy0=o_bsy1=1, o_rdy0=o_rdy1=0, last-granted=1 (so requester 0 wins first), gap counter=0.
REQ-031 After i_rst deasserts, the first arbitration SHALL occur on the next rising edge.

Verification
REQ-032 Single grant: i_req0=1 from IDLE -> o_gnt0=1 next cycle; i_wr0 with wdata 8'hA5 -> o_wr=1 with o_wdata=8'hA5 in the same cycle.
REQ-033 Simultaneous requests: i_req0=i_req1=1 after reset -> GNT0 first. Drop i_req0 -> DRAIN, then GAPWAIT (4 cycles) -> GNT1; o_gnt1 rises exactly 6 cycles after o_gnt0 falls when i_bsy=0 throughout.
REQ-034 Drain with unread byte: release while i_rdy=1, i_rdata=8'h3C -> one-cycle o_rd pulse in DRAIN; o_rdy0/o_rdy1 stay 0; GAPWAIT entered after i_rdy falls.
REQ-035 Busy hold: release while i_bsy=1 for 10 cycles -> remain in DRAIN 10 cycles; no grant; o_wr=0 throughout.
REQ-036 Lockout: i_wr1=1 while GNT0 -> o_wr follows i_wr0 only; o_bsy1=1, o_rdy1=0.
REQ-037 Reset mid-grant: i_rst pulsed in GNT1 -> o_gnt1=0 asynchronously; after release with both requests high -> GNT0.
